// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - RV32I ALU decode/issue stage with register file and busy scoreboard
// Optional WB_BYPASS_EN: same-cycle writeback data is forwarded to sources and clears their hazard.
module alu_issue_stage #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  output logic [3:0]        ALUOp,
  output logic [DATA_W-1:0] opA,
  output logic [DATA_W-1:0] opB,
  output logic              issue_valid,
  output logic [4:0]        rd_out,
  output logic              illegal,
  input  logic              wb_en,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data
);

  localparam logic [DATA_W-1:0] SHAMT_MASK = {{(DATA_W-SHAMT_W){1'b0}}, {SHAMT_W{1'b1}}};

  logic [DATA_W-1:0] rf [32];
  logic [31:0]       busy;
  logic [31:0]       busy_next;

  logic [6:0]        opcode;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic [4:0]        rs1, rs2, rd;
  logic              legal, use_rs2, is_imm, is_shift;
  logic [3:0]        dec_op;
  logic              rs1_busy, rs2_busy;
  logic [DATA_W-1:0] rs1_val, rs2_val, opb_raw, opb_val;
  logic              wb_hit;
  logic              accept, issue;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign f7     = instr[31:25];
  assign wb_hit = wb_en && (wb_rd != 5'd0);

  always_comb begin
    legal    = 1'b0;
    use_rs2  = 1'b0;
    is_imm   = 1'b0;
    is_shift = 1'b0;
    dec_op   = 4'd0;
    case (opcode)
      7'b0110011: begin
        use_rs2 = 1'b1;
        case ({f7, f3})
          10'b0000000_000: begin legal = 1'b1; dec_op = 4'd0; end
          10'b0100000_000: begin legal = 1'b1; dec_op = 4'd1; end
          10'b0000000_111: begin legal = 1'b1; dec_op = 4'd2; end
          10'b0000000_110: begin legal = 1'b1; dec_op = 4'd3; end
          10'b0000000_100: begin legal = 1'b1; dec_op = 4'd4; end
          10'b0000000_001: begin legal = 1'b1; dec_op = 4'd5; is_shift = 1'b1; end
          10'b0000000_101: begin legal = 1'b1; dec_op = 4'd6; is_shift = 1'b1; end
          default: legal = 1'b0;
        endcase
      end
      7'b0010011: begin
        is_imm = 1'b1;
        case (f3)
          3'b000: begin legal = 1'b1; dec_op = 4'd0; end
          3'b111: begin legal = 1'b1; dec_op = 4'd2; end
          3'b110: begin legal = 1'b1; dec_op = 4'd3; end
          3'b100: begin legal = 1'b1; dec_op = 4'd4; end
          3'b001: begin legal = (f7 == 7'd0); dec_op = 4'd5; is_shift = 1'b1; end
          3'b101: begin legal = (f7 == 7'd0); dec_op = 4'd6; is_shift = 1'b1; end
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

  // Sources: x0 reads zero and is never busy; bypass lets a same-cycle writeback satisfy the hazard.
  always_comb begin
    rs1_val  = (rs1 == 5'd0) ? '0 : rf[rs1];
    rs2_val  = (rs2 == 5'd0) ? '0 : rf[rs2];
    rs1_busy = (rs1 != 5'd0) && busy[rs1];
    rs2_busy = (rs2 != 5'd0) && busy[rs2];
`ifdef WB_BYPASS_EN
    if (wb_hit && (wb_rd == rs1)) begin
      rs1_val  = wb_data;
      rs1_busy = 1'b0;
    end
    if (wb_hit && (wb_rd == rs2)) begin
      rs2_val  = wb_data;
      rs2_busy = 1'b0;
    end
`endif
  end

  always_comb begin
    opb_raw = rs2_val;
    if (is_imm)
      opb_raw = is_shift ? {{(DATA_W-5){1'b0}}, instr[24:20]}
                         : {{(DATA_W-12){instr[31]}}, instr[31:20]};
    opb_val = is_shift ? (opb_raw & SHAMT_MASK) : opb_raw;
  end

  assign instr_ready = !rst && (!legal || (!rs1_busy && !(use_rs2 && rs2_busy)));
  assign accept      = instr_valid && instr_ready;
  assign issue       = accept && legal;

  // Set after clear, so an issue and a writeback to the same rd leave it busy.
  always_comb begin
    busy_next = busy;
    if (wb_hit)
      busy_next[wb_rd] = 1'b0;
    if (issue && (rd != 5'd0))
      busy_next[rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++)
        rf[i] <= '0;
    end else if (wb_hit) begin
      rf[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy        <= '0;
      ALUOp       <= 4'd0;
      opA         <= '0;
      opB         <= '0;
      rd_out      <= 5'd0;
      issue_valid <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      busy        <= busy_next;
      issue_valid <= issue;
      illegal     <= accept && !legal;
      if (issue) begin
        ALUOp  <= dec_op;
        opA    <= rs1_val;
        opB    <= opb_val;
        rd_out <= rd;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed self-checking bench for alu_issue_stage
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [3:0]  ALUOp;
  logic [31:0] opA, opB;
  logic        issue_valid;
  logic [4:0]  rd_out;
  logic        illegal;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;

  alu_issue_stage dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .ALUOp(ALUOp), .opA(opA), .opB(opB), .issue_valid(issue_valid), .rd_out(rd_out),
    .illegal(illegal), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    wb_en = 1'b1; wb_rd = r; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic send(input logic [31:0] ins);
    instr = ins; instr_valid = 1'b1;
    #1;
    for (int n = 0; n < 20 && !instr_ready; n++) tick();
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++; $display("FAIL send_timeout got ready=%b exp 1 instr=%h", instr_ready, ins);
    end
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_valid = 1'b0; instr = 32'd0; wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    #3;
    checks++;
    if ({issue_valid, illegal, ALUOp, rd_out} !== 11'd0 || opA !== 32'd0 || opB !== 32'd0) begin
      errors++; $display("FAIL reset_outputs got iv=%b il=%b op=%h rd=%0d a=%h b=%h exp all 0",
                         issue_valid, illegal, ALUOp, rd_out, opA, opB);
    end
    checks++;
    if (instr_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got %b exp 0", instr_ready);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_rtype();
    wb(5'd1, 32'd7);
    wb(5'd2, 32'd3);
    send(r_type(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3));
    checks++;
    if (issue_valid !== 1'b1 || ALUOp !== 4'b0001 || opA !== 32'd7 || opB !== 32'd3 || rd_out !== 5'd3) begin
      errors++; $display("FAIL sub_issue got iv=%b op=%h a=%h b=%h rd=%0d exp 1 1 7 3 3",
                         issue_valid, ALUOp, opA, opB, rd_out);
    end
    tick();
    checks++;
    if (issue_valid !== 1'b0 || ALUOp !== 4'b0001 || opA !== 32'd7) begin
      errors++; $display("FAIL idle_hold got iv=%b op=%h a=%h exp 0 1 7", issue_valid, ALUOp, opA);
    end
    wb(5'd3, 32'd4);
    send(r_type(7'b0000000, 5'd2, 5'd1, 3'b100, 5'd10));
    checks++;
    if (issue_valid !== 1'b1 || ALUOp !== 4'b0100 || opA !== 32'd7 || opB !== 32'd3 || rd_out !== 5'd10) begin
      errors++; $display("FAIL xor_issue got iv=%b op=%h a=%h b=%h rd=%0d exp 1 4 7 3 10",
                         issue_valid, ALUOp, opA, opB, rd_out);
    end
    wb(5'd10, 32'd4);
  endtask

  task automatic test_imm();
    send(i_type(12'hFFF, 5'd0, 3'b000, 5'd4, OP_IMM));
    checks++;
    if (issue_valid !== 1'b1 || ALUOp !== 4'b0000 || opA !== 32'd0 || opB !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL addi_neg got iv=%b op=%h a=%h b=%h exp 1 0 0 ffffffff",
                         issue_valid, ALUOp, opA, opB);
    end
    wb(5'd4, 32'hFFFF_FFFF);
    send(i_type({7'd0, 5'd1}, 5'd4, 3'b001, 5'd6, OP_IMM));
    checks++;
    if (issue_valid !== 1'b1 || ALUOp !== 4'b0101 || opA !== 32'hFFFF_FFFF || opB !== 32'd1) begin
      errors++; $display("FAIL slli got iv=%b op=%h a=%h b=%h exp 1 5 ffffffff 1",
                         issue_valid, ALUOp, opA, opB);
    end
    wb(5'd6, 32'd0);
    wb(5'd2, 32'h23);
    send(r_type(7'b0000000, 5'd2, 5'd1, 3'b001, 5'd11));
    checks++;
    if (ALUOp !== 4'b0101 || opA !== 32'd7 || opB !== 32'd3) begin
      errors++; $display("FAIL sll_mask got op=%h a=%h b=%h exp 5 7 3", ALUOp, opA, opB);
    end
    wb(5'd11, 32'd0);
    send(i_type(12'h800, 5'd1, 3'b110, 5'd13, OP_IMM));
    checks++;
    if (ALUOp !== 4'b0011 || opA !== 32'd7 || opB !== 32'hFFFF_F800) begin
      errors++; $display("FAIL ori got op=%h a=%h b=%h exp 3 7 fffff800", ALUOp, opA, opB);
    end
    wb(5'd13, 32'd0);
    send(i_type(12'd1, 5'd0, 3'b000, 5'd0, OP_IMM));
    checks++;
    if (issue_valid !== 1'b1 || rd_out !== 5'd0) begin
      errors++; $display("FAIL addi_x0 got iv=%b rd=%0d exp 1 0", issue_valid, rd_out);
    end
    instr = r_type(7'd0, 5'd0, 5'd0, 3'b000, 5'd12);
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++; $display("FAIL x0_not_busy got ready=%b exp 1", instr_ready);
    end
  endtask

  task automatic test_stall();
    send(r_type(7'd0, 5'd1, 5'd1, 3'b000, 5'd7));
    instr = r_type(7'd0, 5'd1, 5'd7, 3'b000, 5'd8); instr_valid = 1'b1;
    #1;
    checks++;
    if (instr_ready !== 1'b0) begin
      errors++; $display("FAIL raw_stall got ready=%b exp 0", instr_ready);
    end
    tick();
    checks++;
    if (instr_ready !== 1'b0 || issue_valid !== 1'b0) begin
      errors++; $display("FAIL raw_hold got ready=%b iv=%b exp 0 0", instr_ready, issue_valid);
    end
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'd14;
    #1;
`ifdef WB_BYPASS_EN
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++; $display("FAIL bypass_ready got %b exp 1", instr_ready);
    end
    tick();
    wb_en = 1'b0; instr_valid = 1'b0;
`else
    checks++;
    if (instr_ready !== 1'b0) begin
      errors++; $display("FAIL wb_cycle_ready got %b exp 0", instr_ready);
    end
    tick();
    wb_en = 1'b0;
    checks++;
    if (issue_valid !== 1'b0 || instr_ready !== 1'b1) begin
      errors++; $display("FAIL post_wb got iv=%b ready=%b exp 0 1", issue_valid, instr_ready);
    end
    tick();
    instr_valid = 1'b0;
`endif
    checks++;
    if (issue_valid !== 1'b1 || ALUOp !== 4'b0000 || opA !== 32'd14 || opB !== 32'd7 || rd_out !== 5'd8) begin
      errors++; $display("FAIL dep_issue got iv=%b op=%h a=%h b=%h rd=%0d exp 1 0 e 7 8",
                         issue_valid, ALUOp, opA, opB, rd_out);
    end
    wb(5'd8, 32'd0);
  endtask

  task automatic test_illegal();
    send(i_type(12'd5, 5'd0, 3'b000, 5'd12, OP_IMM));
    instr = i_type(12'd0, 5'd12, 3'b010, 5'd13, OP_LOAD); instr_valid = 1'b1;
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++; $display("FAIL lw_ready got %b exp 1", instr_ready);
    end
    tick();
    instr_valid = 1'b0;
    checks++;
    if (illegal !== 1'b1 || issue_valid !== 1'b0 || ALUOp !== 4'b0000 || opB !== 32'd5) begin
      errors++; $display("FAIL lw_pulse got il=%b iv=%b op=%h b=%h exp 1 0 0 5",
                         illegal, issue_valid, ALUOp, opB);
    end
    tick();
    checks++;
    if (illegal !== 1'b0) begin
      errors++; $display("FAIL lw_one_cycle got il=%b exp 0", illegal);
    end
    send(i_type({7'b0100000, 5'd2}, 5'd1, 3'b101, 5'd14, OP_IMM));
    checks++;
    if (illegal !== 1'b1 || issue_valid !== 1'b0) begin
      errors++; $display("FAIL srai_illegal got il=%b iv=%b exp 1 0", illegal, issue_valid);
    end
    instr = r_type(7'd0, 5'd14, 5'd13, 3'b000, 5'd15);
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++; $display("FAIL illegal_no_busy got ready=%b exp 1", instr_ready);
    end
    instr = r_type(7'd0, 5'd0, 5'd12, 3'b000, 5'd15);
    #1;
    checks++;
    if (instr_ready !== 1'b0) begin
      errors++; $display("FAIL busy12_kept got ready=%b exp 0", instr_ready);
    end
    tick();
    wb(5'd12, 32'd0);
  endtask

  task automatic test_same_edge();
    instr = r_type(7'd0, 5'd0, 5'd1, 3'b000, 5'd9); instr_valid = 1'b1;
    wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'h55;
    tick();
    wb_en = 1'b0; instr_valid = 1'b0;
    checks++;
    if (issue_valid !== 1'b1 || rd_out !== 5'd9) begin
      errors++; $display("FAIL same_edge_issue got iv=%b rd=%0d exp 1 9", issue_valid, rd_out);
    end
    instr = r_type(7'd0, 5'd0, 5'd9, 3'b000, 5'd15);
    #1;
    checks++;
    if (instr_ready !== 1'b0) begin
      errors++; $display("FAIL same_edge_busy got ready=%b exp 0", instr_ready);
    end
    tick();
    wb(5'd9, 32'h66);
    send(r_type(7'd0, 5'd0, 5'd9, 3'b000, 5'd15));
    checks++;
    if (opA !== 32'h66) begin
      errors++; $display("FAIL x9_read got a=%h exp 66", opA);
    end
    wb(5'd15, 32'd0);
  endtask

  task automatic test_reset_mid();
    wb(5'd5, 32'h77);
    send(r_type(7'd0, 5'd0, 5'd5, 3'b000, 5'd16));
    checks++;
    if (opA !== 32'h77) begin
      errors++; $display("FAIL nonbusy_wb got a=%h exp 77", opA);
    end
    send(i_type(12'd3, 5'd0, 3'b000, 5'd5, OP_IMM));
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h99;
    rst = 1'b1;
    #1;
    checks++;
    if ({issue_valid, illegal, ALUOp, rd_out} !== 11'd0 || opA !== 32'd0 || opB !== 32'd0 || instr_ready !== 1'b0) begin
      errors++; $display("FAIL mid_reset got iv=%b il=%b op=%h rd=%0d a=%h b=%h rdy=%b exp all 0",
                         issue_valid, illegal, ALUOp, rd_out, opA, opB, instr_ready);
    end
    tick();
    wb_en = 1'b0; rst = 1'b0;
    instr = r_type(7'd0, 5'd16, 5'd5, 3'b000, 5'd17); instr_valid = 1'b1;
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++; $display("FAIL busy_cleared got ready=%b exp 1", instr_ready);
    end
    tick();
    instr_valid = 1'b0;
    checks++;
    if (issue_valid !== 1'b1 || opA !== 32'd0 || opB !== 32'd0) begin
      errors++; $display("FAIL x5_cleared got iv=%b a=%h b=%h exp 1 0 0", issue_valid, opA, opB);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_imm();
    test_stall();
    test_illegal();
    test_same_edge();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
